// File: rtl/pwm_output_if.sv
`default_nettype none
// ============================================================================
// Interface   : pwm_output_if
// Description : Decoded DShot frame inputs and PWM/status outputs of pwm_output.
// Revision    : 1.0 - initial release
// ============================================================================
interface pwm_output_if;
    logic        frame_valid;
    logic [10:0] set_speed;
    logic [5:0]  special_command;
    logic        is_special_command;
    logic        crc_valid;
    logic        pwm_out;
    logic        armed;
    logic        failsafe;

    modport master (
        output frame_valid,
        output set_speed,
        output special_command,
        output is_special_command,
        output crc_valid,
        input  pwm_out,
        input  armed,
        input  failsafe
    );

    modport slave (
        input  frame_valid,
        input  set_speed,
        input  special_command,
        input  is_special_command,
        input  crc_valid,
        output pwm_out,
        output armed,
        output failsafe
    );
endinterface
`default_nettype wire

// File: rtl/pwm_output.sv
`default_nettype none
// ============================================================================
// Module      : pwm_output
// Description : Servo-style PWM driver for an ESC fed by decoded DShot frames,
//               gated by a zero-throttle arming sequence. The loss-of-signal
//               timeout and FAILSAFE state exist only when the macro
//               PWM_OUTPUT_FAILSAFE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_output #(
    parameter int unsigned CLK_HZ     = 16000000,
    parameter int unsigned PERIOD_US  = 2500,
    parameter int unsigned MIN_US     = 1000,
    parameter int unsigned ARM_FRAMES = 10,
    parameter int unsigned TIMEOUT_US = 50000
) (
    input  logic        clk,
    input  logic        reset_n,
    pwm_output_if.slave pwm_if
);

    localparam int unsigned c_TICKS_PER_US = CLK_HZ / 1000000;
    localparam int unsigned c_PERIOD_TICKS = PERIOD_US * c_TICKS_PER_US;
    localparam int unsigned c_MIN_TICKS    = MIN_US * c_TICKS_PER_US;

    localparam logic [15:0] c_PERIOD_LAST = 16'(c_PERIOD_TICKS - 1);
    localparam logic [15:0] c_MIN_W       = 16'(c_MIN_TICKS);
    localparam logic [7:0]  c_ARM_TARGET  = 8'(ARM_FRAMES);
    localparam logic [10:0] c_SPEED_MAX   = 11'd1999;
    localparam bit          c_FIRST_ARMS  = (ARM_FRAMES <= 1);

    localparam logic [1:0] c_ST_DISARMED = 2'd0;
    localparam logic [1:0] c_ST_ARMING   = 2'd1;
    localparam logic [1:0] c_ST_ARMED    = 2'd2;
`ifdef PWM_OUTPUT_FAILSAFE_EN
    localparam logic [1:0] c_ST_FAILSAFE = 2'd3;
`endif

    generate
        if ((CLK_HZ % 1000000) != 0 || c_TICKS_PER_US == 0) begin : g_chk_clk
            $error("pwm_output: CLK_HZ must be a nonzero multiple of 1 MHz");
        end
        if (c_PERIOD_TICKS == 0 || c_PERIOD_TICKS > 65535) begin : g_chk_period
            $error("pwm_output: PERIOD_US*TICKS_PER_US must be within 1..65535");
        end
        if (ARM_FRAMES < 1 || ARM_FRAMES > 255) begin : g_chk_arm
            $error("pwm_output: ARM_FRAMES must be within 1..255");
        end
        if (TIMEOUT_US == 0) begin : g_chk_timeout
            $error("pwm_output: TIMEOUT_US must be nonzero");
        end
    endgenerate

    logic [1:0]  state_q,   state_d;
    logic [7:0]  arm_cnt_q, arm_cnt_d;
    logic [15:0] pend_q,    pend_d;
    logic [15:0] active_q,  active_d;
    logic [15:0] cnt_q,     cnt_d;
    logic        pwm_q,     pwm_d;

    logic        w_accept;
    logic        w_zero_cmd;
    logic        w_throttle;
    logic        w_wrap;
    logic [7:0]  w_arm_inc;
    logic [10:0] w_speed_clamped;
    logic [15:0] w_width_ticks;
    logic        w_armed;
    logic        w_failsafe;
    logic        w_pwm_en;

    assign w_accept   = pwm_if.frame_valid & pwm_if.crc_valid;
    assign w_zero_cmd = w_accept & pwm_if.is_special_command
                        & (pwm_if.special_command == 6'd0);
    assign w_throttle = w_accept & ~pwm_if.is_special_command;
    assign w_arm_inc  = arm_cnt_q + 8'd1;
    assign w_wrap     = (cnt_q == c_PERIOD_LAST);

    assign w_speed_clamped = (pwm_if.set_speed > c_SPEED_MAX) ? c_SPEED_MAX : pwm_if.set_speed;
    assign w_width_ticks   = 16'((MIN_US + (32'(w_speed_clamped) >> 1)) * c_TICKS_PER_US);

`ifdef PWM_OUTPUT_FAILSAFE_EN
    localparam int unsigned c_TIMEOUT_TICKS = TIMEOUT_US * c_TICKS_PER_US;
    localparam int unsigned c_TO_W          = $clog2(c_TIMEOUT_TICKS + 1);
    localparam logic [c_TO_W-1:0] c_TO_MAX  = c_TO_W'(c_TIMEOUT_TICKS);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(c_TIMEOUT_TICKS - 1);

    logic [c_TO_W-1:0] timeout_q, timeout_d;
    logic              w_timeout_hit;

    // Hit means the counter reaches the limit on this edge.
    assign w_timeout_hit = (timeout_q >= c_TO_LAST);

    always_comb begin
        timeout_d = timeout_q;
        if (w_accept) begin
            timeout_d = '0;
        end else if (timeout_q != c_TO_MAX) begin
            timeout_d = timeout_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timeout_q <= '0;
        end else begin
            timeout_q <= timeout_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= c_ST_DISARMED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        arm_cnt_d = arm_cnt_q;
        case (state_q)
            c_ST_DISARMED: begin
                if (w_zero_cmd) begin
                    arm_cnt_d = 8'd1;
                    state_d   = c_FIRST_ARMS ? c_ST_ARMED : c_ST_ARMING;
                end
            end
            c_ST_ARMING: begin
                // Any strobe that is not a good zero command aborts arming, CRC or not.
                if (pwm_if.frame_valid) begin
                    if (w_zero_cmd) begin
                        arm_cnt_d = w_arm_inc;
                        if (w_arm_inc >= c_ARM_TARGET) begin
                            state_d = c_ST_ARMED;
                        end
                    end else begin
                        arm_cnt_d = '0;
                        state_d   = c_ST_DISARMED;
                    end
                end
`ifdef PWM_OUTPUT_FAILSAFE_EN
                else if (w_timeout_hit) begin
                    state_d = c_ST_FAILSAFE;
                end
`endif
            end
            c_ST_ARMED: begin
`ifdef PWM_OUTPUT_FAILSAFE_EN
                if (!w_accept && w_timeout_hit) begin
                    state_d = c_ST_FAILSAFE;
                end
`endif
            end
`ifdef PWM_OUTPUT_FAILSAFE_EN
            c_ST_FAILSAFE: begin
                if (w_zero_cmd) begin
                    arm_cnt_d = 8'd1;
                    state_d   = c_FIRST_ARMS ? c_ST_ARMED : c_ST_ARMING;
                end
            end
`endif
            default: begin
                arm_cnt_d = '0;
                state_d   = c_ST_DISARMED;
            end
        endcase
    end

    always_comb begin
        w_armed    = 1'b0;
        w_failsafe = 1'b0;
        w_pwm_en   = 1'b1;
        case (state_q)
            c_ST_ARMED: begin
                w_armed = 1'b1;
            end
`ifdef PWM_OUTPUT_FAILSAFE_EN
            c_ST_FAILSAFE: begin
                w_failsafe = 1'b1;
                w_pwm_en   = 1'b0;
            end
`endif
            default: begin
            end
        endcase
    end

    always_comb begin
        pend_d = pend_q;
        if (state_d != c_ST_ARMED) begin
            pend_d = c_MIN_W;
        end else if (state_q == c_ST_ARMED && w_throttle) begin
            pend_d = w_width_ticks;
        end
    end

    // Active width samples the registered pending value, so a frame landing
    // on the wrap cycle only reaches the period after next.
    always_comb begin
        cnt_d    = w_wrap ? 16'd0 : (cnt_q + 16'd1);
        active_d = w_wrap ? pend_q : active_q;
        pwm_d    = w_pwm_en && (cnt_q < active_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arm_cnt_q <= '0;
            pend_q    <= c_MIN_W;
            active_q  <= c_MIN_W;
            cnt_q     <= '0;
            pwm_q     <= 1'b0;
        end else begin
            arm_cnt_q <= arm_cnt_d;
            pend_q    <= pend_d;
            active_q  <= active_d;
            cnt_q     <= cnt_d;
            pwm_q     <= pwm_d;
        end
    end

    assign pwm_if.pwm_out  = pwm_q;
    assign pwm_if.armed    = w_armed;
    assign pwm_if.failsafe = w_failsafe;

endmodule
`default_nettype wire
